feature_stream_tx: RTL and testbench
====================================

FEATURE_STREAM_TX -- requirements
Module: feature_stream_tx

Interface
REQ-001 SHALL have parameter ROWS, default 112: frame height in pixels.
REQ-002 SHALL have parameter COLS, default 112: frame width in pixels.
REQ-003 SHALL have parameter CHANS, default 32: channels per pixel, all carried in one beat.
REQ-004 SHALL have parameter DW, default 16: bits per channel.
REQ-005 SHALL have parameter GAP, default 0: idle cycles inserted between consecutive beats.
REQ-006 SHALL have parameter RD_LAT, default 1, range 1..4: read latency of the external memory in cycles.
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port start  input  1  one-cycle request to stream one frame.
REQ-010 SHALL have port busy  output  1  high from start acceptance until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final beat.
REQ-012 SHALL have port rd_en  output  1  memory read strobe.
REQ-013 SHALL have port rd_addr  output  $clog2(ROWS*COLS)  pixel address, equal to row*COLS+col.
REQ-014 SHALL have port rd_data  input  CHANS*DW  pixel word, valid RD_LAT cycles after rd_en.
REQ-015 SHALL have ports s_valid (1), s_chan ($clog2(CHANS)+1), s_last (1), s_col ($clog2(COLS)+1), s_row ($clog2(ROWS)+1) and s_data (CHANS*DW), all outputs, forming the accelerator input stream.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, GAPWAIT and DRAIN.
REQ-017 SHALL, in IDLE on start=1, clear row and col to 0, set busy on the next edge and enter ISSUE.
REQ-018 SHALL, in ISSUE, assert rd_en for exactly one cycle per pixel, in raster order: col fastest, then row.
REQ-019 SHALL enter GAPWAIT for exactly GAP cycles after each non-final issue when GAP>0, then return to ISSUE.
REQ-020 SHALL enter DRAIN after issuing pixel (ROWS-1, COLS-1) and stay there until that beat has been emitted.
REQ-021 SHALL carry valid, row, col and last for each issue through an RD_LAT-deep shift pipeline aligned with rd_data.
REQ-022 SHALL assert s_valid exactly RD_LAT cycles after the matching rd_en, with s_data equal to rd_data in that cycle.
REQ-023 SHALL hold s_chan at the constant CHANS on every valid beat.
REQ-024 SHALL assert s_last only on the beat with row ROWS-1 and col COLS-1.
REQ-025 SHALL provide no backpressure input; the consumer accepts every beat, and GAP sets the throughput.
REQ-026 SHALL pulse done one cycle after the s_last beat, clear busy in the same cycle and return to IDLE.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL accept a start that arrives in the cycle done is high.
REQ-029 SHALL drive s_row, s_col, s_chan and s_data to 0 whenever s_valid=0.

Reset
REQ-030 SHALL, on reset=1, immediately force the FSM to IDLE, the counters to 0, all pipeline valids to 0, and busy, done, rd_en, rd_addr and every s_* output to 0.
REQ-031 SHALL discard in-flight reads when reset is asserted mid-frame, emit no beat and no done pulse for that frame, and accept start from the first cycle after reset is released.

Configuration
REQ-032 SHALL, with macro FEATURE_TX_PATTERN_EN defined, add input pattern (1 bit); when pattern=1, channel k of the beat at (r,c) carries (r*COLS+c+k) mod 2^DW, rd_data is ignored, and timing is unchanged.
REQ-033 SHALL, without FEATURE_TX_PATTERN_EN, have no pattern port and always source s_data from rd_data.

Structure
REQ-034 SHALL take the FSM state enumeration and the field width constants (chan, col and row widths) from the shared dx120p package.
REQ-035 SHALL contain one sub-module, tx_delay_line, which implements the RD_LAT-deep sideband pipeline.

Verification
REQ-036 SHALL check ROWS=2, COLS=3, GAP=0, RD_LAT=1, start at cycle 0 -> rd_en in cycles 1-6; s_valid in cycles 2-7 with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); s_last only in cycle 7; done in cycle 8.
REQ-037 SHALL check GAP=2, RD_LAT=2, same frame -> beats in cycles 3,6,9,12,15,18 and done in cycle 19.
REQ-038 SHALL check start re-pulsed in cycle 3 of the first test -> exactly 6 beats and a single done.
REQ-039 SHALL check reset asserted in cycle 4 of the first test -> s_valid=0 from cycle 4 and no done; a new start in cycle 10 -> beat (0,0) in cycle 12.
REQ-040 SHALL check, with FEATURE_TX_PATTERN_EN defined and pattern=1, beat (1,2) -> channel 0 equals 5 and channel 31 equals 36.

Source files
------------

// File: rtl/dx120p_pkg.sv
// Shared dx120p definitions: transmit FSM state encoding and the widths of
// the accelerator stream sideband fields (chan, col, row).
package dx120p_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    GAPWAIT = 2'd2,
    DRAIN   = 2'd3
  } tx_state_e;

  // s_chan must be able to hold the value CHANS itself, hence the extra bit
  function automatic int chan_w(input int chans);
    return $clog2(chans) + 1;
  endfunction

  function automatic int col_w(input int cols);
    return $clog2(cols) + 1;
  endfunction

  function automatic int row_w(input int rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/feature_stream_tx_delay.sv
// tx_delay_line: DEPTH-stage shift pipeline that carries per-issue sideband
// (valid, last, chan, row, col) so it lines up with the memory read data.
module tx_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe_r [DEPTH];

  // Shift the sideband one stage per cycle; reset empties every stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_r[i] <= {W{1'b0}};
      end
    end else begin
      pipe_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign q = pipe_r[DEPTH-1];

endmodule

// File: rtl/feature_stream_tx.sv
// feature_stream_tx: reads one ROWS x COLS frame from an external memory in
// raster order and streams each pixel (all CHANS channels in one beat) to
// the accelerator. Optional feature macro: FEATURE_TX_PATTERN_EN adds a
// 'pattern' input that replaces the memory data with a ramp test pattern.
module feature_stream_tx
  import dx120p_pkg::*;
#(
  parameter int ROWS   = 112,
  parameter int COLS   = 112,
  parameter int CHANS  = 32,
  parameter int DW     = 16,
  parameter int GAP    = 0,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
`ifdef FEATURE_TX_PATTERN_EN
  input  logic                          pattern,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [$clog2(ROWS*COLS)-1:0]  rd_addr,
  input  logic [CHANS*DW-1:0]           rd_data,
  output logic                          s_valid,
  output logic [chan_w(CHANS)-1:0]      s_chan,
  output logic                          s_last,
  output logic [col_w(COLS)-1:0]        s_col,
  output logic [row_w(ROWS)-1:0]        s_row,
  output logic [CHANS*DW-1:0]           s_data
);

  localparam int CHAN_W = chan_w(CHANS);
  localparam int COL_W  = col_w(COLS);
  localparam int ROW_W  = row_w(ROWS);
  localparam int ADDR_W = $clog2(ROWS*COLS);
  localparam int GAP_W  = $clog2(GAP + 1) + 1;
`ifdef FEATURE_TX_PATTERN_EN
  localparam int SB_W   = 3 + CHAN_W + ROW_W + COL_W;
`else
  localparam int SB_W   = 2 + CHAN_W + ROW_W + COL_W;
`endif

  tx_state_e           state_r, state_nxt_s;
  logic [ROW_W-1:0]    row_r, row_nxt_s;
  logic [COL_W-1:0]    col_r, col_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [GAP_W-1:0]    gap_r, gap_nxt_s;
  logic                rd_en_r, rd_en_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic                last_pix_s;

  logic [SB_W-1:0]     sb_d_s, sb_q_s;
  logic                sb_valid_s, sb_last_s;
  logic [CHAN_W-1:0]   sb_chan_s;
  logic [ROW_W-1:0]    sb_row_s;
  logic [COL_W-1:0]    sb_col_s;
  logic [CHANS*DW-1:0] data_src_s;

  // row_r/col_r always name the pixel currently being issued
  assign last_pix_s = (row_r == ROW_W'(ROWS - 1)) && (col_r == COL_W'(COLS - 1));

  // State, counters and control outputs; reset returns everything to idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      row_r   <= {ROW_W{1'b0}};
      col_r   <= {COL_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      gap_r   <= {GAP_W{1'b0}};
      rd_en_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      row_r   <= row_nxt_s;
      col_r   <= col_nxt_s;
      addr_r  <= addr_nxt_s;
      gap_r   <= gap_nxt_s;
      rd_en_r <= rd_en_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic: one read per pixel in raster order, GAP idle cycles
  // between reads, then drain until the last beat has left the pipeline
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    addr_nxt_s  = addr_r;
    gap_nxt_s   = gap_r;
    rd_en_nxt_s = 1'b0;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          row_nxt_s   = {ROW_W{1'b0}};
          col_nxt_s   = {COL_W{1'b0}};
          addr_nxt_s  = {ADDR_W{1'b0}};
          rd_en_nxt_s = 1'b1;
          busy_nxt_s  = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      ISSUE: begin
        if (last_pix_s) begin
          state_nxt_s = DRAIN;
        end else begin
          if (col_r == COL_W'(COLS - 1)) begin
            col_nxt_s = {COL_W{1'b0}};
            row_nxt_s = row_r + ROW_W'(1);
          end else begin
            col_nxt_s = col_r + COL_W'(1);
          end
          addr_nxt_s = addr_r + ADDR_W'(1);
          if (GAP > 0) begin
            gap_nxt_s   = {GAP_W{1'b0}};
            state_nxt_s = GAPWAIT;
          end else begin
            rd_en_nxt_s = 1'b1;
          end
        end
      end
      GAPWAIT: begin
        if (gap_r == GAP_W'(GAP - 1)) begin
          rd_en_nxt_s = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          gap_nxt_s   = gap_r + GAP_W'(1);
        end
      end
      DRAIN: begin
        if (sb_last_s) begin
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sideband for the pixel issued this cycle; all-zero when no read is issued
  // so the stream fields come out as zero on idle cycles
  always_comb begin
    if (rd_en_r) begin
`ifdef FEATURE_TX_PATTERN_EN
      sb_d_s = {pattern, last_pix_s, 1'b1, CHAN_W'(CHANS), row_r, col_r};
`else
      sb_d_s = {last_pix_s, 1'b1, CHAN_W'(CHANS), row_r, col_r};
`endif
    end else begin
      sb_d_s = {SB_W{1'b0}};
    end
  end

  tx_delay_line #(
    .W     (SB_W),
    .DEPTH (RD_LAT)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d     (sb_d_s),
    .q     (sb_q_s)
  );

  assign {sb_last_s, sb_valid_s, sb_chan_s, sb_row_s, sb_col_s} =
    sb_q_s[SB_W-2+((SB_W == 3 + CHAN_W + ROW_W + COL_W) ? 0 : 1):0];

`ifdef FEATURE_TX_PATTERN_EN
  logic               sb_pat_s;
  logic [CHANS*DW-1:0] pat_word_s;
  int                 pix_s;

  assign sb_pat_s = sb_q_s[SB_W-1];

  // Ramp pattern: channel k of pixel (r,c) carries r*COLS+c+k, wrapped to DW bits
  always_comb begin
    pix_s      = int'(sb_row_s) * COLS + int'(sb_col_s);
    pat_word_s = {(CHANS*DW){1'b0}};
    for (int k = 0; k < CHANS; k++) begin
      pat_word_s[k*DW +: DW] = DW'(pix_s + k);
    end
  end

  // Pick ramp or memory word for the beat
  always_comb begin
    if (sb_pat_s) begin
      data_src_s = pat_word_s;
    end else begin
      data_src_s = rd_data;
    end
  end
`else
  assign data_src_s = rd_data;
`endif

  // Memory data arrives in the same cycle as its pipelined sideband, so the
  // beat payload is passed straight through and zeroed on idle cycles
  always_comb begin
    if (sb_valid_s) begin
      s_data = data_src_s;
    end else begin
      s_data = {(CHANS*DW){1'b0}};
    end
  end

  assign s_valid = sb_valid_s;
  assign s_last  = sb_last_s;
  assign s_chan  = sb_chan_s;
  assign s_row   = sb_row_s;
  assign s_col   = sb_col_s;
  assign busy    = busy_r;
  assign done    = done_r;
  assign rd_en   = rd_en_r;
  assign rd_addr = addr_r;

endmodule

// File: tb/tb_feature_stream_tx.sv
// Bench for feature_stream_tx: two 2x3 instances (GAP=0/RD_LAT=1 and
// GAP=2/RD_LAT=2) fed by behavioural memories, expected beats queued per
// instance and compared as the stream comes out.
module tb_feature_stream_tx;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b;
`ifdef FEATURE_TX_PATTERN_EN
  logic pattern_a;
`endif

  logic         busy_a, done_a, rd_en_a, s_valid_a, s_last_a;
  logic [2:0]   rd_addr_a, s_col_a;
  logic [1:0]   s_row_a;
  logic [5:0]   s_chan_a;
  logic [511:0] rd_data_a, s_data_a;

  logic         busy_b, done_b, rd_en_b, s_valid_b, s_last_b;
  logic [2:0]   rd_addr_b, s_col_b;
  logic [1:0]   s_row_b;
  logic [5:0]   s_chan_b;
  logic [511:0] rd_data_b, s_data_b, mem_b1;

  typedef struct {
    int           cyc;
    int           row;
    int           col;
    bit           last;
    logic [511:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   exp_done [2];
  int   dones    [2];
  int   cyc      = 0;
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   t0, t1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] mem_word(input int addr);
    logic [511:0] w;
    for (int k = 0; k < 32; k++) w[k*16 +: 16] = 16'(32'hA000 + addr*32 + k);
    return w;
  endfunction

  function automatic logic [511:0] pat_word(input int pix);
    logic [511:0] w;
    for (int k = 0; k < 32; k++) w[k*16 +: 16] = 16'(pix + k);
    return w;
  endfunction

  // memory A: one-cycle latency, junk when not read
  always @(posedge clk)
    rd_data_a <= rd_en_a ? mem_word(int'(rd_addr_a)) : {16{32'hDEADBEEF}};

  // memory B: two-cycle latency
  always @(posedge clk) begin
    mem_b1    <= rd_en_b ? mem_word(int'(rd_addr_b)) : {16{32'hDEADBEEF}};
    rd_data_b <= mem_b1;
  end

  feature_stream_tx #(.ROWS(2), .COLS(3), .CHANS(32), .DW(16), .GAP(0), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
`ifdef FEATURE_TX_PATTERN_EN
    .pattern(pattern_a),
`endif
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .s_valid(s_valid_a), .s_chan(s_chan_a), .s_last(s_last_a),
    .s_col(s_col_a), .s_row(s_row_a), .s_data(s_data_a)
  );

  feature_stream_tx #(.ROWS(2), .COLS(3), .CHANS(32), .DW(16), .GAP(2), .RD_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
`ifdef FEATURE_TX_PATTERN_EN
    .pattern(1'b0),
`endif
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .s_valid(s_valid_b), .s_chan(s_chan_b), .s_last(s_last_b),
    .s_col(s_col_b), .s_row(s_row_b), .s_data(s_data_b)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // queue the beats of one 2x3 frame started in cycle st; beats at or after
  // cycle 'limit' are not expected (frame cut by reset)
  task automatic push_frame(input int d, input int st, input int gap, input int lat,
                            input int limit, input bit pat);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.cyc  = st + 1 + i*(gap + 1) + lat;
      e.row  = i / 3;
      e.col  = i % 3;
      e.last = (i == 5);
      e.data = pat ? pat_word(i) : mem_word(i);
      if (e.cyc < limit) begin
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
      end
    end
  endtask

  task automatic check_dut(input int d, input logic v, input logic last, input logic [5:0] chan,
                           input logic [1:0] row, input logic [2:0] col, input logic [511:0] data,
                           input logic dn, input logic bsy);
    exp_t e;
    logic have;
    have = 1'b0;
    if (v) begin
      if (d == 0) begin
        have = (qa.size() > 0);
        if (have) e = qa.pop_front();
      end else begin
        have = (qb.size() > 0);
        if (have) e = qb.pop_front();
      end
      chk("beat_expected", have, 1'b1);
      if (have) begin
        chk("beat_cycle", cyc, e.cyc);
        chk("beat_row",   row, e.row);
        chk("beat_col",   col, e.col);
        chk("beat_last",  last, e.last);
        chk("beat_chan",  chan, 6'd32);
        chk("beat_data",  data, e.data);
      end
    end else begin
      chk("idle_sideband", {last, chan, row, col}, 12'd0);
      chk("idle_data", data, 512'd0);
    end
    if (dn) begin
      dones[d]++;
      chk("done_cycle", cyc, exp_done[d]);
      chk("done_busy_low", bsy, 1'b0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0, s_valid_a, s_last_a, s_chan_a, s_row_a, s_col_a, s_data_a, done_a, busy_a);
    check_dut(1, s_valid_b, s_last_b, s_chan_b, s_row_b, s_col_b, s_data_b, done_b, busy_b);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
`ifdef FEATURE_TX_PATTERN_EN
    pattern_a = 1'b0;
`endif
    exp_done[0] = -1; exp_done[1] = -1;
    dones[0] = 0;     dones[1] = 0;

    // reset state
    tick(); tick();
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_rd_en_a", rd_en_a, 1'b0);
    chk("rst_rd_addr_a", rd_addr_a, 3'd0);
    chk("rst_valid_a", s_valid_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_rd_en_b", rd_en_b, 1'b0);
    reset = 1'b0;
    tick();

    // frame on A: GAP=0, RD_LAT=1
    t0 = cyc;
    exp_done[0] = t0 + 8;
    push_frame(0, t0, 0, 1, 1 << 30, 1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t1_busy", busy_a, 1'b1);
    chk("t1_addr0", rd_addr_a, 3'd0);
    chk("t1_rd_en", rd_en_a, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("t1_rd_en", rd_en_a, (cyc >= t0 + 1) && (cyc <= t0 + 6));
    end
    chk("t1_done_count", dones[0], 1);
    chk("t1_queue_empty", qa.size(), 0);

    // frame on B: GAP=2, RD_LAT=2
    t0 = cyc;
    exp_done[1] = t0 + 19;
    push_frame(1, t0, 2, 2, 1 << 30, 1'b0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 23; i++) begin
      chk("t2_rd_en", rd_en_b, (cyc >= t0 + 1) && (cyc <= t0 + 16) && ((cyc - t0 - 1) % 3 == 0));
      tick();
    end
    chk("t2_done_count", dones[1], 1);
    chk("t2_queue_empty", qb.size(), 0);

    // start re-pulsed while busy is ignored
    dones[0] = 0;
    t0 = cyc;
    exp_done[0] = t0 + 8;
    push_frame(0, t0, 0, 1, 1 << 30, 1'b0);
    start_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      start_a = (cyc == t0 + 3);
    end
    start_a = 1'b0;
    chk("t3_done_count", dones[0], 1);
    chk("t3_queue_empty", qa.size(), 0);

    // reset mid-frame, then a fresh start
    dones[0] = 0;
    t0 = cyc;
    exp_done[0] = -1;
    push_frame(0, t0, 0, 1, t0 + 4, 1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t4_rst_valid", s_valid_a, 1'b0);
    chk("t4_rst_busy", busy_a, 1'b0);
    chk("t4_rst_rd_en", rd_en_a, 1'b0);
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("t4_no_done", dones[0], 0);
    t1 = cyc;
    chk("t4_restart_cycle", t1, t0 + 10);
    exp_done[0] = t1 + 8;
    push_frame(0, t1, 0, 1, 1 << 30, 1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (11) tick();
    chk("t4_done_count", dones[0], 1);
    chk("t4_queue_empty", qa.size(), 0);

`ifdef FEATURE_TX_PATTERN_EN
    // ramp pattern replaces memory data
    dones[0] = 0;
    pattern_a = 1'b1;
    t0 = cyc;
    exp_done[0] = t0 + 8;
    push_frame(0, t0, 0, 1, 1 << 30, 1'b1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (s_valid_a && s_last_a) begin
        chk("pat_ch0", s_data_a[15:0], 16'd5);
        chk("pat_ch31", s_data_a[511:496], 16'd36);
      end
    end
    pattern_a = 1'b0;
    chk("pat_done_count", dones[0], 1);
    chk("pat_queue_empty", qa.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
